// File: rtl/piece_lock_pkg.sv
// Shared board geometry, cell encoding and FSM state type for piece_lock.
package piece_lock_pkg;

    localparam int BOARD_W      = 10;
    localparam int BOARD_H      = 25;
    localparam int READ_LATENCY = 2;

    localparam logic [5:0] CELL_EMPTY = 6'd0;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_BOUNDS    = 4'd1,
        ST_RD_ADDR   = 4'd2,
        ST_RD_WAIT   = 4'd3,
        ST_RD_SAMPLE = 4'd4,
        ST_WR_ADDR   = 4'd5,
        ST_WR_STROBE = 4'd6,
        ST_WR_END    = 4'd7,
        ST_DONE      = 4'd8
    } pl_state_t;

endpackage

// File: rtl/piece_lock_coord_to_addr.sv
// Converts a board coordinate into a linear board RAM address (y*W + x).
// Only valid for coordinates that already passed the bounds check.
module piece_lock_coord_to_addr
    import piece_lock_pkg::*;
#(
    parameter int BOARD_W_P = BOARD_W
) (
    input  logic [3:0] x,
    input  logic [4:0] y,
    output logic [7:0] addr
);

    // 8-bit arithmetic is enough: the largest legal cell is 249
    assign addr = 8'(y) * 8'(BOARD_W_P) + 8'(x);

endmodule

// File: rtl/piece_lock.sv
// Checks the four cells of a falling piece against the board RAM and, in
// lock mode, stamps the piece colour into those cells when all are free.
module piece_lock
    import piece_lock_pkg::*;
#(
    parameter int BOARD_W_P      = BOARD_W,
    parameter int BOARD_H_P      = BOARD_H,
    parameter int READ_LATENCY_P = READ_LATENCY
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        lock_mode,
    input  logic [15:0] blk_x,
    input  logic [19:0] blk_y,
    input  logic [5:0]  color,
    input  logic [5:0]  ram_Q,
    output logic [7:0]  ram_addr,
    output logic [5:0]  ram_data,
    output logic        ram_wren,
    output logic        collision,
    output logic        locked,
    output logic        complete
);

    localparam logic [3:0] X_LIMIT = 4'(BOARD_W_P);
    localparam logic [4:0] Y_LIMIT = 5'(BOARD_H_P);
    localparam logic [7:0] WAIT_LAST = 8'(READ_LATENCY_P - 2);

    pl_state_t   state_reg,     state_next;
    logic [15:0] lat_x_reg,     lat_x_next;
    logic [19:0] lat_y_reg,     lat_y_next;
    logic [5:0]  color_reg,     color_next;
    logic        mode_reg,      mode_next;
    logic [1:0]  idx_reg,       idx_next;
    logic [7:0]  wait_reg,      wait_next;
    logic [7:0]  addr_reg,      addr_next;
    logic [5:0]  data_reg,      data_next;
    logic        wren_reg,      wren_next;
    logic        collision_reg, collision_next;
    logic        locked_reg,    locked_next;
    logic        complete_reg,  complete_next;

    logic [3:0]  x_arr [4];
    logic [4:0]  y_arr [4];
    logic [3:0]  oob_flags;
    logic [7:0]  cur_addr;

    // Unpack the latched coordinates and flag each block that is off-board
    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
        assign x_arr[gi]     = lat_x_reg[4*gi +: 4];
        assign y_arr[gi]     = lat_y_reg[5*gi +: 5];
        assign oob_flags[gi] = (x_arr[gi] >= X_LIMIT) || (y_arr[gi] >= Y_LIMIT);
    end

    // Single address converter shared by all blocks, selected by idx
    piece_lock_coord_to_addr #(
        .BOARD_W_P (BOARD_W_P)
    ) u_coord_to_addr (
        .x    (x_arr[idx_reg]),
        .y    (y_arr[idx_reg]),
        .addr (cur_addr)
    );

    // State and output registers; reset clears everything immediately
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            lat_x_reg     <= '0;
            lat_y_reg     <= '0;
            color_reg     <= '0;
            mode_reg      <= 1'b0;
            idx_reg       <= '0;
            wait_reg      <= '0;
            addr_reg      <= '0;
            data_reg      <= '0;
            wren_reg      <= 1'b0;
            collision_reg <= 1'b0;
            locked_reg    <= 1'b0;
            complete_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            lat_x_reg     <= lat_x_next;
            lat_y_reg     <= lat_y_next;
            color_reg     <= color_next;
            mode_reg      <= mode_next;
            idx_reg       <= idx_next;
            wait_reg      <= wait_next;
            addr_reg      <= addr_next;
            data_reg      <= data_next;
            wren_reg      <= wren_next;
            collision_reg <= collision_next;
            locked_reg    <= locked_next;
            complete_reg  <= complete_next;
        end
    end

    // Next-state and next-output logic; every register holds by default
    always_comb begin
        state_next     = state_reg;
        lat_x_next     = lat_x_reg;
        lat_y_next     = lat_y_reg;
        color_next     = color_reg;
        mode_next      = mode_reg;
        idx_next       = idx_reg;
        wait_next      = wait_reg;
        addr_next      = addr_reg;
        data_next      = data_reg;
        wren_next      = wren_reg;
        collision_next = collision_reg;
        locked_next    = locked_reg;
        complete_next  = complete_reg;

        if (state_reg != ST_IDLE && !enable) begin
            // Abandoned or acknowledged: back to idle, no rollback of writes
            state_next     = ST_IDLE;
            wren_next      = 1'b0;
            collision_next = 1'b0;
            locked_next    = 1'b0;
            complete_next  = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (enable) begin
                        lat_x_next = blk_x;
                        lat_y_next = blk_y;
                        color_next = color;
                        mode_next  = lock_mode;
                        state_next = ST_BOUNDS;
                    end
                end
                ST_BOUNDS: begin
                    if (|oob_flags) begin
                        collision_next = 1'b1;
                        complete_next  = 1'b1;
                        state_next     = ST_DONE;
                    end else begin
                        idx_next   = '0;
                        state_next = ST_RD_ADDR;
                    end
                end
                ST_RD_ADDR: begin
                    addr_next = cur_addr;
                    wait_next = '0;
                    if (READ_LATENCY_P > 1) begin
                        state_next = ST_RD_WAIT;
                    end else begin
                        state_next = ST_RD_SAMPLE;
                    end
                end
                ST_RD_WAIT: begin
                    if (wait_reg == WAIT_LAST) begin
                        state_next = ST_RD_SAMPLE;
                    end else begin
                        wait_next = wait_reg + 8'd1;
                    end
                end
                ST_RD_SAMPLE: begin
                    if (ram_Q != CELL_EMPTY) begin
                        collision_next = 1'b1;
                        complete_next  = 1'b1;
                        state_next     = ST_DONE;
                    end else if (idx_reg != 2'd3) begin
                        idx_next   = idx_reg + 2'd1;
                        state_next = ST_RD_ADDR;
                    end else if (mode_reg) begin
                        idx_next   = '0;
                        state_next = ST_WR_ADDR;
                    end else begin
                        complete_next = 1'b1;
                        state_next    = ST_DONE;
                    end
                end
                ST_WR_ADDR: begin
                    addr_next  = cur_addr;
                    data_next  = color_reg;
                    state_next = ST_WR_STROBE;
                end
                ST_WR_STROBE: begin
                    wren_next  = 1'b1;
                    state_next = ST_WR_END;
                end
                ST_WR_END: begin
                    wren_next = 1'b0;
                    if (idx_reg != 2'd3) begin
                        idx_next   = idx_reg + 2'd1;
                        state_next = ST_WR_ADDR;
                    end else begin
                        locked_next   = 1'b1;
                        complete_next = 1'b1;
                        state_next    = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_next = ST_DONE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign ram_addr  = addr_reg;
    assign ram_data  = data_reg;
    assign ram_wren  = wren_reg;
    assign collision = collision_reg;
    assign locked    = locked_reg;
    assign complete  = complete_reg;

endmodule

// File: tb/tb_piece_lock.sv
// Scoreboard bench for piece_lock: a behavioural board model predicts the
// result, completion edge and write list of every operation.
module tb_piece_lock;
    import piece_lock_pkg::*;

    localparam int R = 2;

    logic        clk;
    logic        resetn;
    logic        enable;
    logic        lock_mode;
    logic [15:0] blk_x;
    logic [19:0] blk_y;
    logic [5:0]  color;
    logic [5:0]  ram_Q;
    logic [7:0]  ram_addr;
    logic [5:0]  ram_data;
    logic        ram_wren;
    logic        collision;
    logic        locked;
    logic        complete;

    piece_lock dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .lock_mode (lock_mode),
        .blk_x     (blk_x),
        .blk_y     (blk_y),
        .color     (color),
        .ram_Q     (ram_Q),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_wren  (ram_wren),
        .collision (collision),
        .locked    (locked),
        .complete  (complete)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Board RAM: one internal stage plus the registered address gives R=2
    logic [5:0] mem [256];
    logic [5:0] ref_board [256];
    logic [5:0] q_pipe;
    logic       bd_copy;
    assign ram_Q = q_pipe;

    always @(posedge clk) begin
        q_pipe <= mem[ram_addr];
        if (bd_copy) begin
            for (int i = 0; i < 256; i++) mem[i] <= ref_board[i];
        end else if (ram_wren) begin
            mem[ram_addr] <= ram_data;
        end
    end

    int cyc = 0;
    int start_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit    coll;
        bit    lck;
        int    edge_n;
        string name;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [5:0] d;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: completion results and write pulses against the scoreboard
    logic       prev_complete = 1'b0;
    logic       prev_wren = 1'b0;
    logic [7:0] prev_addr = '0;
    logic [5:0] prev_data = '0;

    always @(negedge clk) begin
        if (resetn) begin
            if (complete && !prev_complete) begin
                chk("exp_q_nonempty", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk({e.name, "_collision"}, 32'(collision), 32'(e.coll));
                    chk({e.name, "_locked"}, 32'(locked), 32'(e.lck));
                    chk({e.name, "_edge"}, 32'(cyc - start_cyc), 32'(e.edge_n));
                    $display("op %s: collision=%0d locked=%0d edge=%0d", e.name, collision, locked, cyc - start_cyc);
                end
            end
            if (ram_wren) begin
                chk("wren_not_back_to_back", 32'(prev_wren), 0);
                chk("addr_stable_before", 32'(ram_addr), 32'(prev_addr));
                chk("data_stable_before", 32'(ram_data), 32'(prev_data));
                chk("wr_q_nonempty", 32'(wr_q.size() > 0), 1);
                if (wr_q.size() > 0) begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", 32'(ram_addr), 32'(w.a));
                    chk("wr_data", 32'(ram_data), 32'(w.d));
                end
            end
            if (prev_wren) begin
                chk("addr_stable_after", 32'(ram_addr), 32'(prev_addr));
                chk("data_stable_after", 32'(ram_data), 32'(prev_data));
            end
        end
        prev_complete <= complete;
        prev_wren     <= ram_wren;
        prev_addr     <= ram_addr;
        prev_data     <= ram_data;
    end

    task automatic sync_board();
        bd_copy = 1'b1;
        @(negedge clk);
        bd_copy = 1'b0;
    endtask

    task automatic clear_board();
        for (int i = 0; i < 256; i++) ref_board[i] = CELL_EMPTY;
        sync_board();
    endtask

    task automatic compare_board(input string nm);
        int mism;
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_board[i]) mism++;
        chk({nm, "_board"}, 32'(mism), 0);
    endtask

    // Reference model: decide the outcome from the board contents directly
    task automatic predict(input string nm, input bit lock, input logic [15:0] bx,
                           input logic [19:0] by, input logic [5:0] col);
        int xs[4];
        int ys[4];
        bit oob;
        int k;
        exp_t e;
        oob = 1'b0;
        for (int i = 0; i < 4; i++) begin
            xs[i] = int'((bx >> (4*i)) & 16'hF);
            ys[i] = int'((by >> (5*i)) & 20'h1F);
            if (xs[i] >= BOARD_W || ys[i] >= BOARD_H) oob = 1'b1;
        end
        e.name = nm;
        e.lck  = 1'b0;
        if (oob) begin
            e.coll = 1'b1;
            e.edge_n = 2;
        end else begin
            k = -1;
            for (int i = 0; i < 4; i++)
                if (k < 0 && ref_board[ys[i]*BOARD_W + xs[i]] != CELL_EMPTY) k = i;
            if (k >= 0) begin
                e.coll = 1'b1;
                e.edge_n = 2 + (k + 1) * (R + 1);
            end else begin
                e.coll = 1'b0;
                e.edge_n = 2 + 4 * (R + 1);
                if (lock) begin
                    e.lck = 1'b1;
                    e.edge_n += 12;
                    for (int i = 0; i < 4; i++) begin
                        wr_t w;
                        w.a = 8'(ys[i]*BOARD_W + xs[i]);
                        w.d = col;
                        wr_q.push_back(w);
                        ref_board[ys[i]*BOARD_W + xs[i]] = col;
                    end
                end
            end
        end
        exp_q.push_back(e);
    endtask

    // Driver: one complete enable/complete handshake
    task automatic run_op(input string nm, input bit lock, input logic [15:0] bx,
                          input logic [19:0] by, input logic [5:0] col);
        int n;
        predict(nm, lock, bx, by, col);
        lock_mode = lock;
        blk_x     = bx;
        blk_y     = by;
        color     = col;
        enable    = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        // Inputs must be ignored once latched
        blk_x     = 16'($urandom);
        blk_y     = 20'($urandom);
        color     = 6'($urandom);
        lock_mode = 1'($urandom);
        n = 0;
        while (!complete && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_completed"}, 32'(complete), 1);
        if (!complete && exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
        chk({nm, "_complete_held"}, 32'(complete), 1);
        enable = 1'b0;
        @(negedge clk);
        chk({nm, "_complete_clr"}, 32'(complete), 0);
        chk({nm, "_collision_clr"}, 32'(collision), 0);
        chk({nm, "_locked_clr"}, 32'(locked), 0);
        chk({nm, "_writes_done"}, 32'(wr_q.size()), 0);
        wr_q.delete();
        compare_board(nm);
    endtask

    function automatic logic [15:0] pack_x(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic logic [19:0] pack_y(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    logic [15:0] sq_x;
    logic [19:0] sq_y;

    initial begin
        int n;
        logic [15:0] rx;
        logic [19:0] ry;
        resetn    = 1'b0;
        enable    = 1'b0;
        lock_mode = 1'b0;
        blk_x     = '0;
        blk_y     = '0;
        color     = '0;
        bd_copy   = 1'b0;
        sq_x = pack_x(4, 5, 4, 5);
        sq_y = pack_y(0, 0, 1, 1);
        @(negedge clk);
        clear_board();
        chk("reset_addr", 32'(ram_addr), 0);
        chk("reset_data", 32'(ram_data), 0);
        chk("reset_wren", 32'(ram_wren), 0);
        chk("reset_complete", 32'(complete), 0);
        chk("reset_collision", 32'(collision), 0);
        chk("reset_locked", 32'(locked), 0);
        resetn = 1'b1;
        @(negedge clk);

        run_op("check_empty", 1'b0, sq_x, sq_y, 6'd3);
        run_op("lock_empty", 1'b1, sq_x, sq_y, 6'd3);
        clear_board();
        ref_board[15] = 6'd7;
        sync_board();
        run_op("lock_cell15_busy", 1'b1, sq_x, sq_y, 6'd9);
        run_op("x_wrapped", 1'b0, pack_x(15, 0, 1, 2), pack_y(3, 3, 3, 3), 6'd1);
        run_op("y_floor", 1'b1, pack_x(2, 3, 4, 5), pack_y(24, 24, 24, 25), 6'd1);
        run_op("corner", 1'b1, pack_x(9, 9, 8, 8), pack_y(24, 23, 24, 23), 6'd5);
        run_op("duplicates", 1'b1, pack_x(0, 0, 1, 1), pack_y(5, 5, 5, 5), 6'd2);

        // Abort after the second write pulse: exactly two cells stay written
        clear_board();
        for (int i = 0; i < 2; i++) begin
            wr_t w;
            w.a = (i == 0) ? 8'd4 : 8'd5;
            w.d = 6'd11;
            wr_q.push_back(w);
            ref_board[w.a] = 6'd11;
        end
        lock_mode = 1'b1;
        blk_x = sq_x;
        blk_y = sq_y;
        color = 6'd11;
        enable = 1'b1;
        start_cyc = cyc;
        n = 0;
        for (int t = 0; t < 60 && n < 2; t++) begin
            @(negedge clk);
            if (ram_wren) n++;
        end
        chk("abort_two_pulses", 32'(n), 2);
        enable = 1'b0;
        @(negedge clk);
        chk("abort_wren_low", 32'(ram_wren), 0);
        chk("abort_complete_low", 32'(complete), 0);
        @(negedge clk);
        chk("abort_wren_still_low", 32'(ram_wren), 0);
        chk("abort_writes_done", 32'(wr_q.size()), 0);
        compare_board("abort");
        $display("op abort: two cells written");
        clear_board();
        run_op("reenable_lock", 1'b1, sq_x, sq_y, 6'd11);

        // Asynchronous reset while waiting on a read
        lock_mode = 1'b0;
        blk_x = pack_x(7, 7, 7, 7);
        blk_y = pack_y(20, 20, 20, 20);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("rdwait_addr", 32'(ram_addr), 207);
        #2 resetn = 1'b0;
        #1;
        chk("async_addr", 32'(ram_addr), 0);
        chk("async_data", 32'(ram_data), 0);
        chk("async_wren", 32'(ram_wren), 0);
        chk("async_complete", 32'(complete), 0);
        $display("op async_reset: addr=%0d data=%0d", ram_addr, ram_data);
        @(negedge clk);
        enable = 1'b0;
        resetn = 1'b1;
        @(negedge clk);

        // Randomised operations on sparsely filled boards
        for (int t = 0; t < 30; t++) begin
            if (t % 6 == 0) begin
                for (int i = 0; i < 256; i++)
                    ref_board[i] = ($urandom_range(0, 9) == 0 && i < 250) ? 6'($urandom_range(1, 63)) : CELL_EMPTY;
                sync_board();
            end
            rx = '0;
            ry = '0;
            for (int i = 0; i < 4; i++) begin
                rx[4*i +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                ry[5*i +: 5] = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(25, 31)) : 5'($urandom_range(0, 24));
            end
            run_op($sformatf("rand%0d", t), 1'($urandom), rx, ry, 6'($urandom_range(1, 63)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
